hzd_scoreboard: RTL and testbench

//  Hazard unit for the RV32 pipeline with multi-cycle/long-latency ops. Keeps per-register busy

---
 rtl/hzd_scoreboard.sv | 100 ++++++++++
 tb/tb_hzd_scoreboard.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hzd_scoreboard.sv
// Hazard unit: per-register busy scoreboard for long-latency ops, ID stall generation,
// multi-cycle flush on branch mispredict and saturating stall/flush perf counters.
module hzd_scoreboard #(
   parameter int WIDTH        = 32,
   parameter int INDEX        = 5,
   parameter int MAX_PENDING  = 4,
   parameter int FLUSH_CYCLES = 2,
   localparam int NUM_REGS    = 2**INDEX,
   localparam int PW          = $clog2(MAX_PENDING+1)
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic                idex_mem_read_in,
   input  logic [INDEX-1:0]    idex_rd_in,
   input  logic [INDEX-1:0]    ifid_rs1_in,
   input  logic [INDEX-1:0]    ifid_rs2_in,
   input  logic [INDEX-1:0]    ifid_rd_in,
   input  logic                ifid_long_in,
   input  logic                issue_valid_in,
   input  logic [INDEX-1:0]    issue_rd_in,
   input  logic                wb_valid_in,
   input  logic [INDEX-1:0]    wb_rd_in,
   input  logic                branch_valid_in,
   input  logic                branch_in,
   input  logic                prediction_in,
   output logic                stall_out,
   output logic                flush_out,
   output logic [NUM_REGS-1:0] busy_out,
   output logic [PW-1:0]       pending_out,
   output logic [WIDTH-1:0]    stall_cnt_out,
   output logic [WIDTH-1:0]    flush_cnt_out
);

   localparam int FW = $clog2(FLUSH_CYCLES+1);
   localparam logic [FW-1:0]    FLUSH_LOAD = FW'(FLUSH_CYCLES);
   localparam logic [PW-1:0]    PEND_MAX   = PW'(MAX_PENDING);
   localparam logic [WIDTH-1:0] CNT_MAX    = {WIDTH{1'b1}};

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [PW-1:0]       pending;
   logic [FW-1:0]       flush_ctr;
   logic                mispredict;
   logic                issue_ok;
   logic                load_use;
   logic                raw;
   logic                waw;
   logic                full;
   logic                stall;

   always_comb begin
      pending = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         pending = pending + PW'(busy_q[i]);
      end
   end

   assign mispredict = branch_valid_in & (branch_in != prediction_in);
   assign flush_out  = (flush_ctr != '0);

   // A new register may only become busy while there is room; re-issuing a busy one is free.
   assign issue_ok = issue_valid_in & (issue_rd_in != '0) & ~flush_out &
                     (busy_q[issue_rd_in] | (pending != PEND_MAX));

   always_comb begin
      busy_d = busy_q;
      if (wb_valid_in) busy_d[wb_rd_in] = 1'b0;
      if (issue_ok)    busy_d[issue_rd_in] = 1'b1;
      busy_d[0] = 1'b0;
   end

   assign load_use = idex_mem_read_in & (idex_rd_in != '0) &
                     ((idex_rd_in == ifid_rs1_in) | (idex_rd_in == ifid_rs2_in));
   assign raw      = busy_q[ifid_rs1_in] | busy_q[ifid_rs2_in];
   assign waw      = busy_q[ifid_rd_in];
   assign full     = ifid_long_in & (pending == PEND_MAX);

   // Flush squashes the stalled instruction anyway, so it overrides the stall.
   assign stall = (load_use | raw | waw | full) & ~flush_out & rst_n_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy_q        <= '0;
         flush_ctr     <= '0;
         stall_cnt_out <= '0;
         flush_cnt_out <= '0;
      end else begin
         busy_q <= busy_d;
         if (mispredict) flush_ctr <= FLUSH_LOAD;
         else if (flush_ctr != '0) flush_ctr <= flush_ctr - 1'b1;
         if (stall && stall_cnt_out != CNT_MAX) stall_cnt_out <= stall_cnt_out + 1'b1;
         if (mispredict && flush_cnt_out != CNT_MAX) flush_cnt_out <= flush_cnt_out + 1'b1;
      end
   end

   assign stall_out   = stall;
   assign busy_out    = busy_q;
   assign pending_out = pending;

endmodule

// File: tb/tb_hzd_scoreboard.sv
// Bench for hzd_scoreboard: directed hazard/scoreboard/flush/reset sequences plus a random
// load-use phase; expected outputs queued per step and popped against the DUT.
module tb_hzd_scoreboard;

   localparam int WIDTH = 4;
   localparam int INDEX = 5;

   logic             clk_in = 1'b0;
   logic             rst_n_in;
   logic             idex_mem_read_in;
   logic [INDEX-1:0] idex_rd_in, ifid_rs1_in, ifid_rs2_in, ifid_rd_in;
   logic             ifid_long_in;
   logic             issue_valid_in;
   logic [INDEX-1:0] issue_rd_in;
   logic             wb_valid_in;
   logic [INDEX-1:0] wb_rd_in;
   logic             branch_valid_in, branch_in, prediction_in;
   logic             stall_out, flush_out;
   logic [31:0]      busy_out;
   logic [2:0]       pending_out;
   logic [WIDTH-1:0] stall_cnt_out, flush_cnt_out;

   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic        exp_stall_now = 1'b0;
   int          m_stall = 0;
   logic [31:0] busy_exp;
   int          pend_exp;
   logic        e;

   hzd_scoreboard #(.WIDTH(WIDTH), .INDEX(INDEX), .MAX_PENDING(4), .FLUSH_CYCLES(2)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .idex_mem_read_in(idex_mem_read_in), .idex_rd_in(idex_rd_in),
      .ifid_rs1_in(ifid_rs1_in), .ifid_rs2_in(ifid_rs2_in), .ifid_rd_in(ifid_rd_in),
      .ifid_long_in(ifid_long_in),
      .issue_valid_in(issue_valid_in), .issue_rd_in(issue_rd_in),
      .wb_valid_in(wb_valid_in), .wb_rd_in(wb_rd_in),
      .branch_valid_in(branch_valid_in), .branch_in(branch_in), .prediction_in(prediction_in),
      .stall_out(stall_out), .flush_out(flush_out), .busy_out(busy_out),
      .pending_out(pending_out), .stall_cnt_out(stall_cnt_out), .flush_cnt_out(flush_cnt_out)
   );

   // clock / watchdog
   always #5 clk_in = ~clk_in;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] pop_exp();
      if (exp_q.size() != 0) return exp_q.pop_front();
      return 'x;
   endfunction

   task drive_idle();
      idex_mem_read_in = 1'b0; idex_rd_in = '0;
      ifid_rs1_in = '0; ifid_rs2_in = '0; ifid_rd_in = '0; ifid_long_in = 1'b0;
      issue_valid_in = 1'b0; issue_rd_in = '0;
      wb_valid_in = 1'b0; wb_rd_in = '0;
      branch_valid_in = 1'b0; branch_in = 1'b0; prediction_in = 1'b0;
   endtask

   // Advance one clock; stall counter model follows the stall expected for the ending cycle.
   task tick();
      @(posedge clk_in);
      if (exp_stall_now && m_stall != 15) m_stall++;
      #1;
   endtask

   task check_all(input string tag, input logic e_stall, input logic e_flush,
                  input logic [31:0] e_busy, input int e_pend, input int e_fcnt);
      exp_stall_now = e_stall;
      #3;
      exp_q.push_back({31'b0, e_stall});
      exp_q.push_back({31'b0, e_flush});
      exp_q.push_back(e_busy);
      exp_q.push_back(32'(e_pend));
      exp_q.push_back(32'(m_stall));
      exp_q.push_back(32'(e_fcnt));
      check_val({tag, "_stall"},   {31'b0, stall_out},     pop_exp());
      check_val({tag, "_flush"},   {31'b0, flush_out},     pop_exp());
      check_val({tag, "_busy"},    busy_out,               pop_exp());
      check_val({tag, "_pending"}, {29'b0, pending_out},   pop_exp());
      check_val({tag, "_scnt"},    {28'b0, stall_cnt_out}, pop_exp());
      check_val({tag, "_fcnt"},    {28'b0, flush_cnt_out}, pop_exp());
   endtask

   task reset_dut();
      drive_idle();
      rst_n_in = 1'b0;
      m_stall = 0;
      exp_stall_now = 1'b0;
      #3;
      rst_n_in = 1'b1;
      tick();
   endtask

   initial begin
      drive_idle();
      rst_n_in = 1'b0;
      idex_mem_read_in = 1'b1; idex_rd_in = 5'd5; ifid_rs1_in = 5'd5;
      #12;
      check_all("reset", 0, 0, 0, 0, 0);
      drive_idle();
      rst_n_in = 1'b1;
      tick();

      // load-use
      idex_mem_read_in = 1'b1; idex_rd_in = 5'd5; ifid_rs1_in = 5'd5;
      check_all("lu_rs1", 1, 0, 0, 0, 0); tick();
      idex_rd_in = 5'd0; ifid_rs1_in = 5'd0;
      check_all("lu_x0", 0, 0, 0, 0, 0); tick();
      idex_rd_in = 5'd5; ifid_rs1_in = 5'd3; ifid_rs2_in = 5'd5;
      check_all("lu_rs2", 1, 0, 0, 0, 0); tick();
      idex_mem_read_in = 1'b0;
      check_all("no_load", 0, 0, 0, 0, 0); tick();

      // RAW / WAW / x0
      drive_idle(); issue_valid_in = 1'b1; issue_rd_in = 5'd7;
      check_all("issue7", 0, 0, 0, 0, 0); tick();
      issue_valid_in = 1'b0; ifid_rs2_in = 5'd7;
      check_all("raw", 1, 0, 32'h80, 1, 0); tick();
      wb_valid_in = 1'b1; wb_rd_in = 5'd7;
      check_all("raw_wb", 1, 0, 32'h80, 1, 0); tick();
      wb_valid_in = 1'b0;
      check_all("raw_clr", 0, 0, 0, 0, 0); tick();
      ifid_rs2_in = 5'd0; issue_valid_in = 1'b1; issue_rd_in = 5'd0;
      check_all("x0_issue", 0, 0, 0, 0, 0); tick();
      issue_valid_in = 1'b0;
      check_all("x0_busy", 0, 0, 0, 0, 0); tick();
      issue_valid_in = 1'b1; issue_rd_in = 5'd11;
      check_all("issue11", 0, 0, 0, 0, 0); tick();
      issue_valid_in = 1'b0; ifid_rd_in = 5'd11;
      check_all("waw", 1, 0, 32'h800, 1, 0); tick();
      ifid_rd_in = 5'd0; wb_valid_in = 1'b1; wb_rd_in = 5'd11;
      check_all("waw_wb", 0, 0, 32'h800, 1, 0); tick();
      check_all("wb_idle", 0, 0, 0, 0, 0); tick();
      wb_valid_in = 1'b0;

      // scoreboard full
      busy_exp = 0; pend_exp = 0;
      for (int i = 1; i <= 4; i++) begin
         issue_valid_in = 1'b1; issue_rd_in = 5'(i);
         check_all("fill", 0, 0, busy_exp, pend_exp, 0); tick();
         busy_exp = busy_exp | (32'd1 << i);
         pend_exp++;
      end
      issue_rd_in = 5'd5; ifid_long_in = 1'b1; ifid_rd_in = 5'd20;
      check_all("full", 1, 0, 32'h1E, 4, 0); tick();
      issue_valid_in = 1'b0; wb_valid_in = 1'b1; wb_rd_in = 5'd2;
      check_all("full_wb", 1, 0, 32'h1E, 4, 0); tick();
      wb_valid_in = 1'b0;
      check_all("full_clr", 0, 0, 32'h1A, 3, 0); tick();
      ifid_long_in = 1'b0; ifid_rd_in = 5'd0; issue_valid_in = 1'b1; issue_rd_in = 5'd1;
      check_all("reissue", 0, 0, 32'h1A, 3, 0); tick();

      // simultaneous set/clear on the same register
      issue_rd_in = 5'd9; wb_valid_in = 1'b1; wb_rd_in = 5'd9;
      check_all("setclr", 0, 0, 32'h1A, 3, 0); tick();
      drive_idle();
      check_all("setwin", 0, 0, 32'h21A, 4, 0); tick();

      // flush
      reset_dut();
      branch_valid_in = 1'b1; branch_in = 1'b1; prediction_in = 1'b0;
      check_all("mis", 0, 0, 0, 0, 0); tick();
      drive_idle();
      check_all("fl1", 0, 1, 0, 0, 1); tick();
      check_all("fl2", 0, 1, 0, 0, 1); tick();
      check_all("fl_end", 0, 0, 0, 0, 1); tick();
      branch_valid_in = 1'b1; branch_in = 1'b1; prediction_in = 1'b1;
      check_all("bok", 0, 0, 0, 0, 1); tick();
      drive_idle(); issue_valid_in = 1'b1; issue_rd_in = 5'd13;
      check_all("bok2", 0, 0, 0, 0, 1); tick();
      drive_idle(); branch_valid_in = 1'b1; branch_in = 1'b0; prediction_in = 1'b1;
      check_all("mis2", 0, 0, 32'h2000, 1, 1); tick();
      drive_idle(); issue_valid_in = 1'b1; issue_rd_in = 5'd12;
      idex_mem_read_in = 1'b1; idex_rd_in = 5'd5; ifid_rs1_in = 5'd5; ifid_rs2_in = 5'd13;
      check_all("fl_hzd", 0, 1, 32'h2000, 1, 2); tick();
      drive_idle(); branch_valid_in = 1'b1; branch_in = 1'b1; prediction_in = 1'b0;
      wb_valid_in = 1'b1; wb_rd_in = 5'd13;
      check_all("fl_re", 0, 1, 32'h2000, 1, 2); tick();
      drive_idle();
      check_all("fl_ext1", 0, 1, 0, 0, 3); tick();
      check_all("fl_ext2", 0, 1, 0, 0, 3); tick();
      check_all("fl_done", 0, 0, 0, 0, 3); tick();

      // reset mid-flush with three pending
      reset_dut();
      busy_exp = 0;
      for (int i = 1; i <= 3; i++) begin
         issue_valid_in = 1'b1; issue_rd_in = 5'(i);
         check_all("fill6", 0, 0, busy_exp, i - 1, 0); tick();
         busy_exp = busy_exp | (32'd1 << i);
      end
      issue_valid_in = 1'b0; branch_valid_in = 1'b1; branch_in = 1'b0; prediction_in = 1'b1;
      check_all("pre6", 0, 0, 32'hE, 3, 0); tick();
      drive_idle();
      check_all("pre_rst", 0, 1, 32'hE, 3, 1);
      rst_n_in = 1'b0; m_stall = 0; exp_stall_now = 1'b0;
      idex_mem_read_in = 1'b1; idex_rd_in = 5'd5; ifid_rs1_in = 5'd5;
      #1;
      check_all("async_rst", 0, 0, 0, 0, 0);
      drive_idle();
      rst_n_in = 1'b1;
      tick();
      check_all("post_rst", 0, 0, 0, 0, 0); tick();

      // random load-use with an empty scoreboard
      for (int i = 0; i < 24; i++) begin
         idex_mem_read_in = 1'($urandom_range(0, 1));
         idex_rd_in  = 5'($urandom_range(0, 3));
         ifid_rs1_in = 5'($urandom_range(0, 3));
         ifid_rs2_in = 5'($urandom_range(0, 3));
         e = idex_mem_read_in && idex_rd_in != 0 &&
             (idex_rd_in == ifid_rs1_in || idex_rd_in == ifid_rs2_in);
         check_all("rand", e, 0, 0, 0, 0); tick();
      end

      // stall counter saturation (4-bit)
      idex_mem_read_in = 1'b1; idex_rd_in = 5'd5; ifid_rs1_in = 5'd5; ifid_rs2_in = 5'd0;
      for (int i = 0; i < 20; i++) begin
         check_all("sat", 1, 0, 0, 0, 0); tick();
      end
      drive_idle();
      check_all("sat_end", 0, 0, 0, 0, 0);
      check_val("sat15", {28'b0, stall_cnt_out}, 32'd15);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
